// File: rtl/entropy_pkg.sv
// Shared types and constants for the entropy debiaser: extractor states,
// drop-counter width and the legality check on the harvested-bit count.
package entropy_pkg;

  typedef enum logic {
    IDLE,
    EXTRACT
  } state_t;

  localparam int unsigned DROP_CNT_W = 8;

  // Pairs are formed from adjacent harvested bits, so the count must be even.
  function automatic bit lsb_take_legal(input int unsigned lsb_take,
                                        input int unsigned sample_w);
    return (lsb_take % 2 == 0) && (lsb_take >= 2) && (lsb_take <= sample_w);
  endfunction

endpackage

// File: rtl/entropy_debiaser_bit_fifo.sv
// 1-bit-wide show-ahead FIFO holding debiased bits; flush empties it at once.
module bit_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic SCLK,
  input  logic RST,
  input  logic push,
  input  logic push_bit,
  input  logic pop,
  input  logic flush,
  output logic head_bit,
  output logic empty,
  output logic full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_pop;
  logic             do_push;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push  = push && (!full || do_pop);
  assign head_bit = !empty && mem[rd_ptr];

  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge SCLK) begin
    if (do_push && !flush) mem[wr_ptr] <= push_bit;
  end

endmodule

// File: rtl/entropy_debiaser.sv
// Von Neumann debiaser over the low bits of raw sensor samples, with a
// repetition-count health test and a small output FIFO.
module entropy_debiaser
  import entropy_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned LSB_TAKE   = 4,
  parameter int unsigned RCT_CUTOFF = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  SCLK,
  input  logic                  RST,
  input  logic [SAMPLE_W-1:0]   SAMPLE,
  input  logic                  SAMPLE_VALID,
  output logic                  SAMPLE_READY,
  output logic                  RAND_BIT,
  output logic                  BIT_VALID,
  input  logic                  BIT_READY,
  output logic                  HEALTH_FAIL,
  output logic [DROP_CNT_W-1:0] DROP_CNT
);

  if (!lsb_take_legal(LSB_TAKE, SAMPLE_W)) begin : g_bad_lsb_take
    $error("entropy_debiaser: LSB_TAKE must be even and within 2..SAMPLE_W");
  end

  localparam int unsigned RW = $clog2(RCT_CUTOFF + 1);
  localparam int unsigned KW = (LSB_TAKE > 2) ? $clog2(LSB_TAKE / 2) : 1;
  localparam logic [RW-1:0] CUT       = RW'(RCT_CUTOFF);
  localparam logic [KW-1:0] LAST_PAIR = KW'(LSB_TAKE / 2 - 1);

  state_t                state;
  logic [LSB_TAKE-1:0]   shreg;
  logic [KW-1:0]         pair_idx;
  logic [SAMPLE_W-1:0]   prev_sample;
  logic [RW-1:0]         rep_cnt;
  logic [RW-1:0]         rep_next;
  logic                  health_fail;
  logic [DROP_CNT_W-1:0] drop_cnt;

  logic accept;
  logic trip;
  logic pair_push;
  logic fifo_pop;
  logic fifo_empty;
  logic fifo_full;
  logic dropped;

  assign SAMPLE_READY = (state == IDLE) && !health_fail;
  assign accept       = SAMPLE_VALID && SAMPLE_READY;
  assign trip         = accept && (rep_next == CUT);
  assign pair_push    = (state == EXTRACT) && (shreg[0] != shreg[1]) && !health_fail;
  assign fifo_pop     = BIT_VALID && BIT_READY;
  assign dropped      = pair_push && fifo_full && !fifo_pop;

  always_comb begin
    rep_next = RW'(1);
    if ((SAMPLE == prev_sample) && (rep_cnt != '0))
      rep_next = (rep_cnt == CUT) ? rep_cnt : rep_cnt + 1'b1;
  end

  // The current pair always sits in shreg[1:0]; shifting by two exposes the next.
  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      shreg       <= '0;
      pair_idx    <= '0;
      prev_sample <= '0;
      rep_cnt     <= '0;
      health_fail <= 1'b0;
    end else if (accept) begin
      prev_sample <= SAMPLE;
      rep_cnt     <= rep_next;
      if (trip) begin
        health_fail <= 1'b1;
        state       <= IDLE;
      end else begin
        shreg    <= SAMPLE[LSB_TAKE-1:0];
        pair_idx <= '0;
        state    <= EXTRACT;
      end
    end else if (state == EXTRACT) begin
      shreg    <= shreg >> 2;
      pair_idx <= pair_idx + 1'b1;
      if (pair_idx == LAST_PAIR) state <= IDLE;
    end
  end

  always_ff @(posedge SCLK or posedge RST) begin
    if (RST)
      drop_cnt <= '0;
    else if (dropped && !health_fail && (drop_cnt != '1))
      drop_cnt <= drop_cnt + 1'b1;
  end

  bit_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .SCLK    (SCLK),
    .RST     (RST),
    .push    (pair_push),
    .push_bit(shreg[0]),
    .pop     (fifo_pop),
    .flush   (trip),
    .head_bit(RAND_BIT),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign BIT_VALID   = !fifo_empty && !health_fail;
  assign HEALTH_FAIL = health_fail;
  assign DROP_CNT    = drop_cnt;

endmodule

// File: tb/tb_entropy_debiaser.sv
// Directed bench for entropy_debiaser with hand-computed expectations.
module tb_entropy_debiaser;

  logic        SCLK = 1'b0;
  logic        RST  = 1'b1;
  logic [15:0] SAMPLE = '0;
  logic        SAMPLE_VALID = 1'b0;
  logic        SAMPLE_READY;
  logic        RAND_BIT;
  logic        BIT_VALID;
  logic        BIT_READY = 1'b0;
  logic        HEALTH_FAIL;
  logic [7:0]  DROP_CNT;

  int n_checks = 0;
  int n_pass   = 0;

  entropy_debiaser #(
    .SAMPLE_W  (16),
    .LSB_TAKE  (4),
    .RCT_CUTOFF(4),
    .FIFO_DEPTH(8)
  ) dut (
    .SCLK        (SCLK),
    .RST         (RST),
    .SAMPLE      (SAMPLE),
    .SAMPLE_VALID(SAMPLE_VALID),
    .SAMPLE_READY(SAMPLE_READY),
    .RAND_BIT    (RAND_BIT),
    .BIT_VALID   (BIT_VALID),
    .BIT_READY   (BIT_READY),
    .HEALTH_FAIL (HEALTH_FAIL),
    .DROP_CNT    (DROP_CNT)
  );

  always #5 SCLK = ~SCLK;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge SCLK);
    #1;
  endtask

  // Presents one sample; returns 1 ns after the accept edge.
  task automatic send(input logic [15:0] s);
    int waited = 0;
    while (!SAMPLE_READY && waited < 50) begin
      tick(1);
      waited++;
    end
    if (!SAMPLE_READY) check_eq("ready_timeout", 0, 1);
    SAMPLE       = s;
    SAMPLE_VALID = 1'b1;
    tick(1);
    SAMPLE_VALID = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset values, single extracted bit from 0x0001
    do_reset();
    check_eq("rst_ready", int'(SAMPLE_READY), 1);
    check_eq("rst_valid", int'(BIT_VALID), 0);
    check_eq("rst_bit", int'(RAND_BIT), 0);
    check_eq("rst_hf", int'(HEALTH_FAIL), 0);
    check_eq("rst_drop", int'(DROP_CNT), 0);

    send(16'h0001);
    check_eq("t1_ready_busy", int'(SAMPLE_READY), 0);
    check_eq("t1_valid_n", int'(BIT_VALID), 0);
    tick(1);
    check_eq("t1_valid_n1", int'(BIT_VALID), 1);
    check_eq("t1_bit", int'(RAND_BIT), 1);
    tick(1);
    check_eq("t1_ready_back", int'(SAMPLE_READY), 1);
    check_eq("t1_still_one", int'(BIT_VALID), 1);
    BIT_READY = 1'b1;
    tick(1);
    check_eq("t1_only_one", int'(BIT_VALID), 0);

    // 2: 0x0006 gives 0 then 1 with consumer always ready
    send(16'h0006);
    check_eq("t2_ready_c0", int'(SAMPLE_READY), 0);
    check_eq("t2_valid_c0", int'(BIT_VALID), 0);
    tick(1);
    check_eq("t2_ready_c1", int'(SAMPLE_READY), 0);
    check_eq("t2_valid_c1", int'(BIT_VALID), 1);
    check_eq("t2_bit0", int'(RAND_BIT), 0);
    tick(1);
    check_eq("t2_ready_c2", int'(SAMPLE_READY), 1);
    check_eq("t2_valid_c2", int'(BIT_VALID), 1);
    check_eq("t2_bit1", int'(RAND_BIT), 1);
    tick(1);
    check_eq("t2_drained", int'(BIT_VALID), 0);

    // 3: samples whose harvested pairs are all equal (0xC -> pairs 00, 11)
    send(16'h000F); tick(2);
    check_eq("t3_valid_0f", int'(BIT_VALID), 0);
    send(16'h0000); tick(2);
    check_eq("t3_valid_00", int'(BIT_VALID), 0);
    send(16'h00FC); tick(2);
    check_eq("t3_valid_fc", int'(BIT_VALID), 0);
    check_eq("t3_drop", int'(DROP_CNT), 0);

    // 4: overflow, 20 bits into 8 slots
    BIT_READY = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send((i % 2 == 0) ? 16'h0009 : 16'h0109);
      tick(2);
    end
    check_eq("t4_drop", int'(DROP_CNT), 12);
    check_eq("t4_valid", int'(BIT_VALID), 1);
    BIT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("t4_valid_%0d", i), int'(BIT_VALID), 1);
      check_eq($sformatf("t4_bit_%0d", i), int'(RAND_BIT), (i % 2 == 0) ? 1 : 0);
      tick(1);
    end
    check_eq("t4_empty", int'(BIT_VALID), 0);
    BIT_READY = 1'b0;

    // 5: repetition-count trip on the fourth identical sample
    for (int i = 0; i < 3; i++) begin
      send(16'h0AB5);
      tick(2);
    end
    check_eq("t5_hf_before", int'(HEALTH_FAIL), 0);
    check_eq("t5_valid_before", int'(BIT_VALID), 1);
    send(16'h0AB5);
    check_eq("t5_hf", int'(HEALTH_FAIL), 1);
    check_eq("t5_flush", int'(BIT_VALID), 0);
    check_eq("t5_ready", int'(SAMPLE_READY), 0);
    check_eq("t5_drop_frozen", int'(DROP_CNT), 12);
    SAMPLE       = 16'h0001;
    SAMPLE_VALID = 1'b1;
    tick(6);
    SAMPLE_VALID = 1'b0;
    check_eq("t5_ignored_valid", int'(BIT_VALID), 0);
    check_eq("t5_sticky", int'(HEALTH_FAIL), 1);
    do_reset();
    check_eq("t5_rst_hf", int'(HEALTH_FAIL), 0);
    check_eq("t5_rst_ready", int'(SAMPLE_READY), 1);
    check_eq("t5_rst_drop", int'(DROP_CNT), 0);
    check_eq("t5_rst_valid", int'(BIT_VALID), 0);

    // 6: reset during extraction discards the sample and restarts the count
    send(16'h0006);
    RST = 1'b1;
    tick(1);
    check_eq("t6_valid_in_rst", int'(BIT_VALID), 0);
    RST = 1'b0;
    tick(1);
    check_eq("t6_valid_after", int'(BIT_VALID), 0);
    check_eq("t6_ready_after", int'(SAMPLE_READY), 1);
    BIT_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(16'h0006);
      tick(2);
    end
    check_eq("t6_hf_three", int'(HEALTH_FAIL), 0);
    send(16'h0006);
    check_eq("t6_hf_four", int'(HEALTH_FAIL), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
